// File: rtl/alu_result_flags_if.sv
// Handshake and data bundle between the ALU datapath, the result/flag
// buffer and the writeback stage.
interface alu_result_flags_if;
  // Upstream op offer
  logic [7:0] Result;
  logic       AddCarry;
  logic       ShiftCarry;
  logic       OverflowIn;
  logic       CarrySel;
  logic       FlagWE;
  logic       ZChain;
  logic       InValid;
  logic       InReady;
  // Writeback side
  logic       OutValid;
  logic       OutReady;
  logic [7:0] OutData;
  logic [3:0] OutFlags;
  // Control and carry feedback
  logic       Flush;
  logic       LCarryIn;

  // Side that offers ops and consumes results
  modport master (
    output Result, AddCarry, ShiftCarry, OverflowIn, CarrySel, FlagWE, ZChain,
    output InValid, OutReady, Flush,
    input  InReady, OutValid, OutData, OutFlags, LCarryIn
  );

  // Result/flag buffer side
  modport slave (
    input  Result, AddCarry, ShiftCarry, OverflowIn, CarrySel, FlagWE, ZChain,
    input  InValid, OutReady, Flush,
    output InReady, OutValid, OutData, OutFlags, LCarryIn
  );
endinterface

// File: rtl/alu_result_flags.sv
// ALU flag generation ({N,V,Z,C}) with a 2-entry result/flag FIFO toward
// writeback. The flag register updates only on accepted ops with FlagWE,
// and its C bit is fed back to the shifter as LCarryIn.
module alu_result_flags (
  input  logic              AluClock,
  input  logic              Reset,
  alu_result_flags_if.slave bus
);

  // Flag vector layout is {N, V, Z, C}
  function automatic logic [3:0] calc_flags(
    input logic [7:0] result,
    input logic       add_carry,
    input logic       shift_carry,
    input logic       overflow_in,
    input logic       carry_sel,
    input logic       z_chain,
    input logic [3:0] cur_flags
  );
    logic n_v, v_v, z_v, c_v;
    n_v = result[7];
    // Shifts leave V untouched; arithmetic takes the adder overflow
    v_v = carry_sel ? cur_flags[2] : overflow_in;
    // Chained compares only stay zero if every earlier byte was zero
    z_v = (result == 8'h00) & (z_chain ? cur_flags[1] : 1'b1);
    c_v = carry_sel ? shift_carry : add_carry;
    return {n_v, v_v, z_v, c_v};
  endfunction

  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0][7:0]  data_q, data_d;
  logic [1:0][3:0]  eflags_q, eflags_d;
  logic [3:0]       flag_q, flag_d;

  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;
  logic [3:0]       new_flags_s;
  logic [3:0]       entry_flags_s;

  // Handshake qualifiers and the flags an accepted op would produce
  always_comb begin
    in_ready_s    = ~Reset & (count_q < 2'd2) & ~bus.Flush;
    push_s        = bus.InValid & in_ready_s;
    // Flush wins over a simultaneous pop so nothing is emitted twice
    pop_s         = (count_q != 2'd0) & bus.OutReady & ~bus.Flush;
    new_flags_s   = calc_flags(bus.Result, bus.AddCarry, bus.ShiftCarry,
                               bus.OverflowIn, bus.CarrySel, bus.ZChain, flag_q);
    if (bus.FlagWE) begin
      entry_flags_s = new_flags_s;
    end else begin
      entry_flags_s = flag_q;
    end
  end

  // Next-state for FIFO storage, pointers, occupancy and flag register
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    eflags_d = eflags_q;
    flag_d   = flag_q;

    if (bus.Flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push_s) begin
        data_d[wr_ptr_q]   = bus.Result;
        eflags_d[wr_ptr_q] = entry_flags_s;
        wr_ptr_d           = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end

    // Flush blocks push, so the flag register is also held on flush
    if (push_s & bus.FlagWE) begin
      flag_d = new_flags_s;
    end else begin
      flag_d = flag_q;
    end
  end

  // State registers; reset clears storage so outputs read as zero
  always_ff @(posedge AluClock or posedge Reset) begin
    if (Reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      data_q   <= '{default: 8'h00};
      eflags_q <= '{default: 4'h0};
      flag_q   <= 4'b0000;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      data_q   <= data_d;
      eflags_q <= eflags_d;
      flag_q   <= flag_d;
    end
  end

  // Outputs are taken straight from registers (InReady excepted)
  always_comb begin
    bus.InReady  = in_ready_s;
    bus.OutValid = (count_q != 2'd0);
    bus.OutData  = data_q[rd_ptr_q];
    bus.OutFlags = eflags_q[rd_ptr_q];
    bus.LCarryIn = flag_q[0];
  end

endmodule
